// File: rtl/seq_pkg.sv
// Shared types for the note sequencer: FSM states, table entry layout and field widths.
package seq_pkg;

    localparam int FREQ_W = 64;
    localparam int DUR_W  = 8;

    // A duration of zero marks the end of the melody.
    localparam logic [DUR_W-1:0] END_DUR = '0;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        PLAY,
        GAP,
        DONE
    } seq_state_e;

    typedef struct packed {
        logic [FREQ_W-1:0] freq;
        logic [DUR_W-1:0]  dur;
    } note_entry_t;

endpackage

// File: rtl/beat_timer.sv
// Beat prescaler: strobes on the last clk of each beat while enabled; clr restarts the beat.
module beat_timer #(
    parameter int CLKS_PER_BEAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic beat
);

    localparam int CW = (CLKS_PER_BEAT > 1) ? $clog2(CLKS_PER_BEAT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BEAT - 1);

    logic [CW-1:0] cnt;

    assign beat = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= beat ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Melody player: walks a {freq, dur} table and drives the divider's freq_value plus a note gate.
// Handshake: start/stop are single-cycle pulses sampled on clk; stop beats start; start is honoured only from IDLE.
module note_sequencer
    import seq_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int CLKS_PER_BEAT = 4,
    parameter int GAP_CYCLES    = 2,
    localparam int ADDR_W       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [FREQ_W-1:0] wr_freq,
    input  logic [DUR_W-1:0]  wr_dur,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    output logic [FREQ_W-1:0] freq_value,
    output logic              note_on,
    output logic [ADDR_W-1:0] note_idx,
    output logic              busy,
    output logic              done,
    output logic [2:0]        state_dbg
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    seq_state_e        state_q, state_d, adv_state;
    logic [ADDR_W-1:0] idx_q, idx_d, adv_idx;
    note_entry_t       mem [DEPTH];
    note_entry_t       rd_q;
    logic [DUR_W-1:0]  beats_left_q;
    logic [GW-1:0]     gap_cnt_q;
    logic              beat, last_play_cycle, gap_last;

    logic [FREQ_W-1:0] freq_d;
    logic              note_on_d, busy_d, done_d;
    logic [ADDR_W-1:0] note_idx_d;

    assign state_dbg = state_q;

    // Registered-read table; a write in the same cycle as the fetch returns the old contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= '{freq: wr_freq, dur: wr_dur};
        end
        if (state_q == FETCH) begin
            rd_q <= mem[idx_q];
        end
    end

    beat_timer #(.CLKS_PER_BEAT(CLKS_PER_BEAT)) u_beat (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_q != PLAY),
        .en   (state_q == PLAY),
        .beat (beat)
    );

    assign last_play_cycle = beat && (beats_left_q == DUR_W'(1));
    assign gap_last        = (gap_cnt_q == GW'(GAP_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            beats_left_q <= '0;
            gap_cnt_q    <= '0;
        end else begin
            if (state_q == DECODE) begin
                beats_left_q <= rd_q.dur;
            end else if (state_q == PLAY && beat) begin
                beats_left_q <= beats_left_q - DUR_W'(1);
            end
            gap_cnt_q <= (state_q == GAP) ? gap_cnt_q + GW'(1) : '0;
        end
    end

    // Running off the end of the table is handled like an end marker.
    always_comb begin
        adv_state = FETCH;
        adv_idx   = idx_q + ADDR_W'(1);
        if (idx_q == LAST_IDX) begin
            if (loop_en) begin
                adv_idx = '0;
            end else begin
                adv_state = DONE;
                adv_idx   = idx_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    idx_d   = '0;
                end
            end
            FETCH:  state_d = DECODE;
            DECODE: begin
                if (rd_q.dur == END_DUR) begin
                    if (loop_en && idx_q != '0) begin
                        state_d = FETCH;
                        idx_d   = '0;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (last_play_cycle) begin
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                    end else begin
                        state_d = adv_state;
                        idx_d   = adv_idx;
                    end
                end
            end
            GAP: begin
                if (gap_last) begin
                    state_d = adv_state;
                    idx_d   = adv_idx;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (stop) begin
            state_d = IDLE;
        end
    end

    // Next values of the registered outputs; the note is latched once on DECODE->PLAY.
    always_comb begin
        freq_d     = freq_value;
        note_on_d  = note_on;
        note_idx_d = note_idx;
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
        if (state_q == DECODE && state_d == PLAY) begin
            freq_d     = rd_q.freq;
            note_on_d  = (rd_q.freq != '0);
            note_idx_d = idx_q;
        end else if (state_d != PLAY) begin
            freq_d    = '0;
            note_on_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            freq_value <= '0;
            note_on    <= 1'b0;
            note_idx   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            freq_value <= freq_d;
            note_on    <= note_on_d;
            note_idx   <= note_idx_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: a timeline model expands each table entry into its expected output cycles.
module tb_note_sequencer;
    import seq_pkg::*;

    localparam int DEPTH     = 8;
    localparam int CPB       = 4;
    localparam int GAP_N     = 2;
    localparam int P_NONE    = 0;
    localparam int P_ADV     = 1;
    localparam int P_RESTART = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [2:0]        wr_addr = '0;
    logic [FREQ_W-1:0] wr_freq = '0;
    logic [DUR_W-1:0]  wr_dur = '0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              loop_en = 1'b0;
    logic [FREQ_W-1:0] freq_value;
    logic              note_on;
    logic [2:0]        note_idx;
    logic              busy;
    logic              done;
    logic [2:0]        state_dbg;

    note_sequencer #(.DEPTH(DEPTH), .CLKS_PER_BEAT(CPB), .GAP_CYCLES(GAP_N)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_freq(wr_freq),
        .wr_dur(wr_dur), .start(start), .stop(stop), .loop_en(loop_en),
        .freq_value(freq_value), .note_on(note_on), .note_idx(note_idx),
        .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [FREQ_W-1:0] freq;
        logic              note_on;
        logic              set_idx;
        logic [2:0]        idx;
        logic              busy;
        logic              done;
    } exp_t;

    exp_t              exp_q[$];
    logic [FREQ_W-1:0] m_freq [DEPTH];
    logic [DUR_W-1:0]  m_dur [DEPTH];
    bit                m_active = 0;
    bit                m_valid = 0;
    int                m_pend = P_NONE;
    int                m_idx = 0;
    logic [FREQ_W-1:0] e_freq = '0;
    logic              e_on = 1'b0;
    logic [2:0]        e_idx = '0;
    logic              e_busy = 1'b0;
    logic              e_done = 1'b0;

    logic [FREQ_W-1:0] obs_f[$];
    logic              obs_on[$];
    logic [2:0]        obs_idx[$];
    logic              obs_busy[$];
    logic              obs_done[$];

    function automatic void push_cycle(input logic [FREQ_W-1:0] f, input logic on,
                                       input logic set, input logic [2:0] ix, input logic dn);
        exp_t x;
        x.freq = f; x.note_on = on; x.set_idx = set; x.idx = ix; x.busy = 1'b1; x.done = dn;
        exp_q.push_back(x);
    endfunction

    // One entry = fetch+decode silence, dur*CPB sounding cycles, GAP_N silent cycles.
    function automatic void refill();
        logic [FREQ_W-1:0] f;
        int d;
        if (m_pend == P_ADV) begin
            if (m_idx == DEPTH - 1) begin
                if (loop_en) m_idx = 0;
                else begin
                    push_cycle('0, 1'b0, 1'b0, '0, 1'b1);
                    m_active = 0;
                    return;
                end
            end else begin
                m_idx++;
            end
        end else if (m_pend == P_RESTART) begin
            m_idx = 0;
        end
        f = m_freq[m_idx];
        d = int'(m_dur[m_idx]);
        repeat (2) push_cycle('0, 1'b0, 1'b0, '0, 1'b0);
        if (d == 0) begin
            if (loop_en && m_idx != 0) m_pend = P_RESTART;
            else begin
                push_cycle('0, 1'b0, 1'b0, '0, 1'b1);
                m_active = 0;
            end
        end else begin
            repeat (d * CPB) push_cycle(f, f != '0, 1'b1, 3'(m_idx), 1'b0);
            repeat (GAP_N) push_cycle('0, 1'b0, 1'b0, '0, 1'b0);
            m_pend = P_ADV;
        end
    endfunction

    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            if (wr_en) begin
                m_freq[wr_addr] = wr_freq;
                m_dur[wr_addr]  = wr_dur;
            end
            if (rst) begin
                exp_q.delete(); m_active = 0;
                e_freq = '0; e_on = 1'b0; e_idx = '0; e_busy = 1'b0; e_done = 1'b0;
            end else if (stop) begin
                exp_q.delete(); m_active = 0;
                e_freq = '0; e_on = 1'b0; e_busy = 1'b0; e_done = 1'b0;
            end else begin
                if (start && !e_busy) begin
                    m_active = 1; m_idx = 0; m_pend = P_NONE;
                end
                if (m_active && exp_q.size() == 0) refill();
                if (exp_q.size() != 0) begin
                    x = exp_q.pop_front();
                    e_freq = x.freq; e_on = x.note_on; e_busy = x.busy; e_done = x.done;
                    if (x.set_idx) e_idx = x.idx;
                end else begin
                    e_freq = '0; e_on = 1'b0; e_busy = 1'b0; e_done = 1'b0;
                end
            end
            m_valid = 1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                checks++;
                if (freq_value !== e_freq || note_on !== e_on || note_idx !== e_idx ||
                    busy !== e_busy || done !== e_done) begin
                    failures++;
                    $display("FAIL cycle_cmp t=%0t got f=%0d on=%0b idx=%0d busy=%0b done=%0b need f=%0d on=%0b idx=%0d busy=%0b done=%0b",
                             $time, freq_value, note_on, note_idx, busy, done,
                             e_freq, e_on, e_idx, e_busy, e_done);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d need=%0d", nm, got, want);
        end
    endtask

    function automatic logic [FREQ_W-1:0] rand_freq();
        if ($urandom_range(0, 3) == 0) return '0;
        return {$urandom, $urandom};
    endfunction

    function automatic int count_freq(input logic [FREQ_W-1:0] f);
        int n = 0;
        foreach (obs_f[i]) if (obs_on[i] && obs_f[i] == f) n++;
        return n;
    endfunction

    function automatic int count_on();
        int n = 0;
        foreach (obs_on[i]) if (obs_on[i]) n++;
        return n;
    endfunction

    function automatic int count_done();
        int n = 0;
        foreach (obs_done[i]) if (obs_done[i]) n++;
        return n;
    endfunction

    function automatic int done_at();
        foreach (obs_done[i]) if (obs_done[i]) return i + 1;
        return -1;
    endfunction

    task automatic wr(input int a, input logic [FREQ_W-1:0] f, input logic [DUR_W-1:0] d);
        wr_en = 1'b1; wr_addr = 3'(a); wr_freq = f; wr_dur = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic load_t1();
        wr(0, 100, 2); wr(1, 0, 1); wr(2, 200, 1); wr(3, 5, 0);
        for (int i = 4; i < DEPTH; i++) wr(i, 7, 1);
    endtask

    // Pulses start at cycle 0 and records outputs; cycle k is observed at the k-th negedge after.
    task automatic run_watch(input int ncyc, input bit until_idle, input int xstart_at,
                             input int wr_at, input logic [2:0] wa, input logic [FREQ_W-1:0] wf,
                             input logic [DUR_W-1:0] wd, input bit rnd, output bit to);
        obs_f.delete(); obs_on.delete(); obs_idx.delete(); obs_busy.delete(); obs_done.delete();
        to = until_idle;
        for (int k = 0; k <= ncyc; k++) begin
            if (k >= 1) begin
                obs_f.push_back(freq_value); obs_on.push_back(note_on);
                obs_idx.push_back(note_idx); obs_busy.push_back(busy); obs_done.push_back(done);
                if (until_idle && k >= 2 && !busy) begin
                    to = 0;
                    break;
                end
            end
            if (k < ncyc) begin
                start = (k == 0) || (k == xstart_at) || (rnd && $urandom_range(0, 7) == 0);
                stop  = rnd && ($urandom_range(0, 39) == 0);
                wr_en = 1'b0;
                if (k == wr_at) begin
                    wr_en = 1'b1; wr_addr = wa; wr_freq = wf; wr_dur = wd;
                end else if (rnd && $urandom_range(0, 3) == 0) begin
                    wr_en = 1'b1; wr_addr = 3'($urandom_range(0, 7));
                    wr_freq = rand_freq(); wr_dur = 8'($urandom_range(0, 3));
                end
                @(negedge clk);
            end
        end
        start = 1'b0; stop = 1'b0; wr_en = 1'b0;
    endtask

    initial begin
        bit to;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_freq", freq_value, 0);
        chk("rst_note_on", note_on, 0);
        chk("rst_note_idx", note_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;

        load_t1();
        loop_en = 1'b0;
        run_watch(60, 1, -1, -1, 0, 0, 0, 0, to);
        chk("t1_timeout", to, 0);
        chk("t1_done_at", done_at(), 31);
        chk("t1_done_cnt", count_done(), 1);
        chk("t1_n100", count_freq(100), 8);
        chk("t1_n200", count_freq(200), 4);
        chk("t1_rest_gate", obs_on[14], 0);
        chk("t1_rest_idx", obs_idx[14], 1);
        chk("t1_busy_with_done", obs_busy[30], 1);
        chk("t1_busy_after", obs_busy[31], 0);

        loop_en = 1'b1;
        run_watch(36, 0, -1, -1, 0, 0, 0, 0, to);
        chk("t2_pre_replay", obs_f[31], 0);
        chk("t2_replay_freq", obs_f[32], 100);
        chk("t2_replay_idx", obs_idx[32], 0);
        chk("t2_no_done", count_done(), 0);
        chk("t2_on_before_stop", obs_on[35], 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("t2_stop_on", note_on, 0);
        chk("t2_stop_freq", freq_value, 0);
        chk("t2_stop_busy", busy, 0);

        wr(0, 5, 0);
        run_watch(20, 1, -1, -1, 0, 0, 0, 0, to);
        chk("t3_timeout", to, 0);
        chk("t3_done_at", done_at(), 3);
        chk("t3_silent", count_on(), 0);
        chk("t3_idle", obs_busy[3], 0);

        loop_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) wr(i, 64'(1000 + i), 1);
        run_watch(100, 1, -1, -1, 0, 0, 0, 0, to);
        chk("t4_timeout", to, 0);
        chk("t4_done_at", done_at(), 65);
        for (int i = 0; i < DEPTH; i++) begin
            chk("t4_freq", obs_f[2 + 8 * i], 64'(1000 + i));
            chk("t4_idx", obs_idx[2 + 8 * i], 64'(i));
        end
        loop_en = 1'b1;
        run_watch(70, 0, -1, -1, 0, 0, 0, 0, to);
        chk("t4_wrap_freq", obs_f[66], 1000);
        chk("t4_wrap_idx", obs_idx[66], 0);
        chk("t4_wrap_no_done", count_done(), 0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        loop_en = 1'b0;

        run_watch(100, 1, 5, -1, 0, 0, 0, 0, to);
        chk("t5_restart_ignored", done_at(), 65);
        run_watch(12, 0, -1, -1, 0, 0, 0, 0, to);
        chk("t5_pre_rst_idx", obs_idx[11], 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_rst_freq", freq_value, 0);
        chk("t5_rst_on", note_on, 0);
        chk("t5_rst_idx", note_idx, 0);
        chk("t5_rst_busy", busy, 0);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk("t5_start_stop_busy", busy, 0);
        @(negedge clk);
        chk("t5_start_stop_busy2", busy, 0);

        load_t1();
        run_watch(60, 1, -1, 5, 2, 300, 1, 0, to);
        chk("t6_timeout", to, 0);
        chk("t6_new_freq", obs_f[22], 300);
        chk("t6_old_gone", count_freq(200), 0);
        run_watch(60, 1, -1, 4, 0, 999, 3, 0, to);
        chk("t6_cur_kept", count_freq(100), 8);
        chk("t6_cur_end", obs_f[10], 0);
        chk("t6_cur_not_heard", count_freq(999), 0);

        for (int it = 0; it < 25; it++) begin
            loop_en = 1'($urandom_range(0, 1));
            for (int a = 0; a < DEPTH; a++) wr(a, rand_freq(), 8'($urandom_range(0, 3)));
            run_watch($urandom_range(20, 120), 0, -1, -1, 0, 0, 0, 1, to);
            stop = 1'b1;
            @(negedge clk);
            stop = 1'b0;
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog t=%0t got=running need=finished", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
